// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned RF_W  = 8;
    localparam int unsigned RF_A  = 3;
    localparam int unsigned RF_LQ = 2;

    // Low bit of field `port` in a packed bus of `width`-bit fields.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/scoreboard_regfile_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
interface scoreboard_regfile_if
    import regfile_pkg::*;
#(
    parameter int unsigned W  = RF_W,
    parameter int unsigned A  = RF_A,
    parameter int unsigned NR = 2
);

    logic [NR-1:0]     ReadEn;
    logic [NR*A-1:0]   Raddr;
    logic [NR*W-1:0]   DataOut;
    logic              WriteEn;
    logic [A-1:0]      Waddr;
    logic [W-1:0]      DataIn;
    logic              LdIssue;
    logic [A-1:0]      LdAddr;
    logic              LdValid;
    logic [W-1:0]      LdData;
    logic [W-1:0]      JumpTarget;
    logic [2**A-1:0]   Pending;
    logic              Stall;
    logic              LdFull;
    logic              ErrWaw;

    modport master (
        output ReadEn, Raddr, WriteEn, Waddr, DataIn, LdIssue, LdAddr, LdValid, LdData,
        input  DataOut, JumpTarget, Pending, Stall, LdFull, ErrWaw
    );

    modport slave (
        input  ReadEn, Raddr, WriteEn, Waddr, DataIn, LdIssue, LdAddr, LdValid, LdData,
        output DataOut, JumpTarget, Pending, Stall, LdFull, ErrWaw
    );

endinterface

// File: rtl/ld_tag_fifo.sv
// In-order queue of destination registers for outstanding loads.
module ld_tag_fifo #(
    parameter int unsigned A  = 3,
    parameter int unsigned LQ = 2
) (
    input  logic                      Clk,
    input  logic                      ResetN,
    input  logic                      Push,
    input  logic [A-1:0]              PushData,
    input  logic                      Pop,
    output logic [A-1:0]              Head,
    output logic                      Full,
    output logic                      Empty,
    output logic [$clog2(LQ+1)-1:0]   Count
);

    localparam int unsigned PW = $clog2(LQ);
    localparam int unsigned CW = $clog2(LQ + 1);

    logic [A-1:0]  mem_q [LQ];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign Full    = (cnt_q == CW'(LQ));
    assign Empty   = (cnt_q == '0);
    assign Count   = cnt_q;
    assign Head    = mem_q[rd_q];
    assign do_pop  = Pop & ~Empty;
    // A pop frees the slot the push lands in, so full+pop+push is legal.
    assign do_push = Push & (~Full | do_pop);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LQ; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= PushData;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with bypassed read ports, a jump-target port and a load scoreboard
// that raises Stall on read-after-load hazards.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned W       = RF_W,
    parameter int unsigned A       = RF_A,
    parameter int unsigned NR      = 2,
    parameter int unsigned LQ      = RF_LQ,
    parameter int unsigned JT_REG  = (2**A) - 1,
    parameter bit          R0_ZERO = 1'b0
) (
    input logic                  Clk,
    input logic                  ResetN,
    scoreboard_regfile_if.slave  bus
);

    localparam int unsigned Depth = 2**A;
    localparam int unsigned CW    = $clog2(LQ + 1);

    logic [W-1:0]     regs_q [Depth];
    logic [W-1:0]     regs_d [Depth];
    logic [CW-1:0]    sc_q   [Depth];
    logic [CW-1:0]    sc_d   [Depth];
    logic             err_q;
    logic             err_d;
    logic [Depth-1:0] pending;

    logic [A-1:0]     ld_head;
    logic             ld_full;
    logic             ld_empty;
    logic [CW-1:0]    ld_count;
    logic             ld_pop;
    logic             ld_push;

    logic [W-1:0]     rd_data [NR];
    logic [NR*W-1:0]  data_out;
    logic [NR-1:0]    stall_vec;

    assign ld_pop  = bus.LdValid & ~ld_empty;
    assign ld_push = bus.LdIssue & (~ld_full | ld_pop);

    ld_tag_fifo #(
        .A  (A),
        .LQ (LQ)
    ) u_ld_tag_fifo (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Push     (ld_push),
        .PushData (bus.LdAddr),
        .Pop      (ld_pop),
        .Head     (ld_head),
        .Full     (ld_full),
        .Empty    (ld_empty),
        .Count    (ld_count)
    );

    // Storage next state: a returning load beats a same-cycle ALU write.
    always_comb begin
        for (int unsigned r = 0; r < Depth; r++) begin
            regs_d[r] = regs_q[r];
            if (!(R0_ZERO && r == 0)) begin
                if (ld_pop && ld_head == A'(r)) begin
                    regs_d[r] = bus.LdData;
                end else if (bus.WriteEn && bus.Waddr == A'(r)) begin
                    regs_d[r] = bus.DataIn;
                end
            end
        end
    end

    // Per-register count of queued loads; an issue and return to the same
    // register in one cycle cancel, leaving the bit set.
    always_comb begin
        for (int unsigned r = 0; r < Depth; r++) begin
            sc_d[r] = sc_q[r] + CW'(ld_push && bus.LdAddr == A'(r))
                              - CW'(ld_pop && ld_head == A'(r));
            pending[r] = (sc_q[r] != '0);
        end
    end

    always_comb begin
        err_d = err_q;
        if (bus.WriteEn && pending[bus.Waddr]) begin
            err_d = 1'b1;
        end
        if (bus.LdIssue && ld_full && !ld_pop) begin
            err_d = 1'b1;
        end
        if (bus.LdValid && ld_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            err_q <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
                sc_q[i]   <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= regs_d[i];
                sc_q[i]   <= sc_d[i];
            end
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [A-1:0] ra;
        logic         ld_hit;
        logic         wr_hit;

        assign ra     = bus.Raddr[slice_lo(i, A) +: A];
        assign ld_hit = ld_pop && (ld_head == ra);
        assign wr_hit = bus.WriteEn && (bus.Waddr == ra);

        always_comb begin
            if (R0_ZERO && ra == '0) begin
                rd_data[i] = '0;
            end else if (ld_hit) begin
                rd_data[i] = bus.LdData;
            end else if (wr_hit) begin
                rd_data[i] = bus.DataIn;
            end else begin
                rd_data[i] = regs_q[ra];
            end
        end

        assign stall_vec[i] = bus.ReadEn[i] & pending[ra] & ~ld_hit;
    end

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            data_out[slice_lo(i, W) +: W] = rd_data[i];
        end
    end

    assign bus.DataOut    = data_out;
    assign bus.Stall      = |stall_vec;
    assign bus.Pending    = pending;
    assign bus.LdFull     = (ld_count == CW'(LQ));
    assign bus.ErrWaw     = err_q;
    assign bus.JumpTarget = regs_q[JT_REG];

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised general-purpose register file for the core datapath, successor to the fixed 8×8 file. Adds N combinational read ports with write-through bypass, a dedicated jump-target read port, and a per-register pending scoreboard. The scoreboard tracks in-flight loads so the decode stage stalls on read-after-load hazards. It sits between decode (reads, load issue) and writeback (ALU writes, load returns).

## Interface
- `W`, 8: register width in bits
- `A`, 3: address width; depth = 2**A
- `NR`, 2: number of read ports
- `LQ`, 2: maximum outstanding loads; power of two, ≥ 2
- `JT_REG`, 2**A-1: index of the register driven on `JumpTarget`
- `R0_ZERO`, 0: when 1, register 0 reads as zero and ignores writes

- `Clk`  in  1  clock, rising edge
- `ResetN`  in  1  asynchronous, active-low reset
- `ReadEn`  in  NR  per-port read qualifier; only used for stall generation
- `Raddr`  in  NR*A  packed read addresses; port i at [i*A +: A]
- `DataOut`  out  NR*W  packed read data; port i at [i*W +: W]
- `WriteEn`  in  1  ALU writeback strobe
- `Waddr`  in  A  ALU writeback address
- `DataIn`  in  W  ALU writeback data
- `LdIssue`  in  1  load issued; marks `LdAddr` pending
- `LdAddr`  in  A  load destination register
- `LdValid`  in  1  load data returning, in issue order
- `LdData`  in  W  returning load data
- `JumpTarget`  out  W  registered contents of `JT_REG`; no bypass
- `Pending`  out  2**A  scoreboard bits
- `Stall`  out  1  a read depends on an unresolved load
- `LdFull`  out  1  load tag queue holds `LQ` entries
- `ErrWaw`  out  1  sticky protocol-error flag

## Operation
- Storage: 2**A × W flops. On reset, all entries are 0.
- Load tag queue: FIFO of `LQ` entries, each A bits wide.
  - `LdIssue` pushes `LdAddr` and sets `Pending[LdAddr]`.
  - `LdValid` pops the head entry H, writes `LdData` to H, and clears `Pending[H]`.
- Read port i returns data in this priority order:
  - `LdValid` and H==Raddr[i] → `LdData`
  - else `WriteEn` and Waddr==Raddr[i] → `DataIn`
  - else the stored value
  - With `R0_ZERO`=1, address 0 always reads 0, and writes or loads to 0 are dropped. Pending[0] still sets and clears normally.
- `Stall` = OR over i of (ReadEn[i] & Pending[Raddr[i]] & !(LdValid & H==Raddr[i])). It is combinational from the current-cycle inputs.
- Boundary cases:
  - `WriteEn` and `LdValid` to the same address in one cycle: `LdData` is stored.
  - `WriteEn` to an address whose Pending bit is set (WAW): the write is performed, the Pending bit stays set, and `ErrWaw` sets. `ErrWaw` clears only on reset.
  - `LdIssue` while `LdFull` and no `LdValid`: the issue is dropped, nothing changes, and `ErrWaw` sets.
  - `LdIssue` while `LdFull` with `LdValid`: the pop happens first and the push is accepted.
  - `LdIssue` and `LdValid` in the same cycle to the same address: the Pending bit ends set, because the new issue takes precedence over the clear.
  - `LdValid` with the queue empty: ignored, and `ErrWaw` sets.
  - Two queued loads to the same register: the Pending bit clears only when the last such entry pops. Track this with a per-register count or by scanning the queue.
- Pointers wrap modulo `LQ`.

## Timing
- Reads and `Stall` are zero-latency (combinational).
- Writes, loads, Pending updates, and queue updates commit on the rising edge of `Clk`.
- `JumpTarget` shows a write to `JT_REG` on the cycle after it commits.
- Reset values: all registers 0, `Pending` 0, queue empty, `LdFull` 0, `ErrWaw` 0, `JumpTarget` 0, `Stall` 0. `DataOut` is 0 unless bypass inputs are active.
- Assertion of `ResetN` mid-operation immediately flushes all in-flight loads and clears every Pending bit. Later `LdValid` pulses with the queue empty are treated as errors.
- Reset release is synchronised externally. The first active edge after deassertion operates normally.

## Structure
- Package `regfile_pkg`: default constants (`RF_W`=8, `RF_A`=3, `RF_LQ`=2) and a function for the packed-port slice index.
- Sub-module `ld_tag_fifo`:
  - parameters A, LQ
  - ports: push, push data, pop, head, full, empty, count
  - implementation: async active-low reset, wrap-around pointers plus count
- Top level: storage array, bypass mux generate loop over NR, scoreboard, and error flag.

## Test plan
- Reset, then `WriteEn` R2=0x5A with Raddr0=2 in the same cycle → DataOut0=0x5A that cycle; the stored value still reads 0x5A the next cycle.
- `LdIssue` R3; next cycle ReadEn0 with Raddr0=3 → Stall=1, Pending[3]=1. `LdValid` with LdData=0xC3 → Stall=0 and DataOut0=0xC3 the same cycle; Pending[3]=0 the next cycle.
- Two `LdIssue` (R1, R4) → LdFull=1. A third issue to R5 with no return is dropped and sets ErrWaw=1. Two returns 0x11 then 0x44 → R1=0x11, R4=0x44, Pending=0.
- `WriteEn` R7=0x80 → JumpTarget=0x80 on the next cycle, not the same cycle.
- Same-cycle `WriteEn` R6=0xAA and `LdValid` to R6 with 0x66 → R6=0x66. With R0_ZERO=1, writing R0=0xFF → R0 reads 0.
- Two loads outstanding, then `ResetN` pulsed low mid-operation → Pending=0, LdFull=0, all registers 0. A subsequent `LdValid` sets ErrWaw=1 and writes nothing.
